// File: rtl/apple2_slot_bus_ctrl_if.sv
// Host request and slot-card bus signals for the Apple II slot bus controller.
// The host side drives cpu_*; the controller drives everything toward the cards.
interface apple2_slot_bus_ctrl_if;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic        ack;
    logic        busy;
    logic [11:0] bus_addr;
    logic        bus_rw;
    logic [7:0]  _devsel;
    logic [7:0]  _iosel;
    logic        _iostrobe;
    logic [2:0]  exp_slot;
    logic        exp_valid;

    modport master (
        output cpu_req, cpu_addr, cpu_rw,
        input  ack, busy, bus_addr, bus_rw, _devsel, _iosel, _iostrobe,
        input  exp_slot, exp_valid
    );

    modport slave (
        input  cpu_req, cpu_addr, cpu_rw,
        output ack, busy, bus_addr, bus_rw, _devsel, _iosel, _iostrobe,
        output exp_slot, exp_valid
    );
endinterface

// File: rtl/apple2_slot_bus_ctrl.sv
// Apple II slot bus cycle generator.
// Accepts one host access at a time, latches address/direction and the slot
// decode, then runs a SETUP / STROBE / HOLD sequence with a single decoded
// active-low select held low only during STROBE. Tracks which slot owns the
// shared C800-CFFF expansion window.
//
//   state  | meaning
//   IDLE   | waiting for cpu_req; ack pulses here for one cycle after HOLD
//   SETUP  | address/direction stable, no strobe yet
//   STROBE | decoded select driven low
//   HOLD   | strobes released, address/direction still held
module apple2_slot_bus_ctrl #(
    parameter int SETUP_CLKS  = 1,
    parameter int STROBE_CLKS = 4,
    parameter int HOLD_CLKS   = 1
) (
    input  logic                         fclk,
    input  logic                         _reset,
    apple2_slot_bus_ctrl_if.slave        bus
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_DEV, SEL_IO, SEL_EXP} sel_t;

    // Phase lengths are loaded as (length - 1) and counted down to zero.
    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CLKS - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CLKS - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CLKS - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic [11:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    sel_t        sel_q, sel_d;
    logic [2:0]  slot_q, slot_d;
    logic [7:0]  devsel_n_q, devsel_n_d;
    logic [7:0]  iosel_n_q, iosel_n_d;
    logic        iostrobe_n_q, iostrobe_n_d;
    logic [2:0]  exp_slot_q, exp_slot_d;
    logic        exp_valid_q, exp_valid_d;

    sel_t        req_sel;
    logic [2:0]  req_slot;

    // Slot decode of the incoming host address; only used on the acceptance edge.
    always_comb begin
        req_sel  = SEL_NONE;
        req_slot = 3'd0;
        if (bus.cpu_addr[15:7] == 9'b1100_0000_1) begin
            req_sel  = SEL_DEV;
            req_slot = bus.cpu_addr[6:4];
        end else if (bus.cpu_addr[15:11] == 5'b11000 && bus.cpu_addr[10:8] != 3'd0) begin
            req_sel  = SEL_IO;
            req_slot = bus.cpu_addr[10:8];
        end else if (bus.cpu_addr[15:11] == 5'b11001) begin
            req_sel  = SEL_EXP;
        end
    end

    // Next-state, phase timer, strobe and expansion-ownership logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ack_d        = 1'b0;
        addr_d       = addr_q;
        rw_d         = rw_q;
        sel_d        = sel_q;
        slot_d       = slot_q;
        devsel_n_d   = 8'hFF;
        iosel_n_d    = 8'hFF;
        iostrobe_n_d = 1'b1;
        exp_slot_d   = exp_slot_q;
        exp_valid_d  = exp_valid_q;

        case (state_q)
            IDLE: begin
                // The ack cycle never accepts, so a held request restarts one cycle later.
                if (bus.cpu_req && !ack_q) begin
                    addr_d  = bus.cpu_addr[11:0];
                    rw_d    = bus.cpu_rw;
                    sel_d   = req_sel;
                    slot_d  = req_slot;
                    cnt_d   = SETUP_LOAD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = STROBE_LOAD;
                    state_d = STROBE;
                    case (sel_q)
                        SEL_DEV: devsel_n_d = ~(8'd1 << slot_q);
                        SEL_IO: begin
                            iosel_n_d   = ~(8'd1 << slot_q);
                            exp_slot_d  = slot_q;
                            exp_valid_d = 1'b1;
                        end
                        SEL_EXP: begin
                            iostrobe_n_d = 1'b0;
                            // CFFF is the card-release address for the expansion window.
                            if (addr_q == 12'hFFF) begin
                                exp_valid_d = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end else begin
                    cnt_d        = cnt_q - 4'd1;
                    devsel_n_d   = devsel_n_q;
                    iosel_n_d    = iosel_n_q;
                    iostrobe_n_d = iostrobe_n_q;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        iosel_n_d[0] = 1'b1;
        busy_d       = (state_d != IDLE) || ack_d;
    end

    // All state and outputs registered; synchronous active-low reset.
    always_ff @(posedge fclk) begin
        if (!_reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            addr_q       <= 12'h000;
            rw_q         <= 1'b1;
            sel_q        <= SEL_NONE;
            slot_q       <= 3'd0;
            devsel_n_q   <= 8'hFF;
            iosel_n_q    <= 8'hFF;
            iostrobe_n_q <= 1'b1;
            exp_slot_q   <= 3'd0;
            exp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            sel_q        <= sel_d;
            slot_q       <= slot_d;
            devsel_n_q   <= devsel_n_d;
            iosel_n_q    <= iosel_n_d;
            iostrobe_n_q <= iostrobe_n_d;
            exp_slot_q   <= exp_slot_d;
            exp_valid_q  <= exp_valid_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.busy      = busy_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_rw    = rw_q;
    assign bus._devsel   = devsel_n_q;
    assign bus._iosel    = iosel_n_q;
    assign bus._iostrobe = iostrobe_n_q;
    assign bus.exp_slot  = exp_slot_q;
    assign bus.exp_valid = exp_valid_q;

endmodule

// File: tb/tb_apple2_slot_bus_ctrl.sv
// Bench for apple2_slot_bus_ctrl: default-timing instance plus a
// SETUP=2/STROBE=1/HOLD=3 instance for back-to-back timing.
module tb_apple2_slot_bus_ctrl;

    localparam int AS = 1, AT = 4, AH = 1;
    localparam int BS = 2, BT = 1, BH = 3;

    logic fclk = 1'b0;
    logic _reset;
    int   checks = 0;
    int   errors = 0;

    logic [2:0] m_exp_slot;
    logic       m_exp_valid;

    always #5 fclk = ~fclk;

    apple2_slot_bus_ctrl_if ifa();
    apple2_slot_bus_ctrl_if ifb();

    apple2_slot_bus_ctrl #(.SETUP_CLKS(AS), .STROBE_CLKS(AT), .HOLD_CLKS(AH)) dut_a (
        .fclk(fclk), ._reset(_reset), .bus(ifa)
    );
    apple2_slot_bus_ctrl #(.SETUP_CLKS(BS), .STROBE_CLKS(BT), .HOLD_CLKS(BH)) dut_b (
        .fclk(fclk), ._reset(_reset), .bus(ifb)
    );

    task automatic next_cycle;
        @(posedge fclk);
        #1;
    endtask

    function automatic logic [31:0] obs_a();
        return {ifa.ack, ifa.busy, ifa.bus_addr, ifa.bus_rw, ifa._devsel, ifa._iosel, ifa._iostrobe};
    endfunction

    function automatic logic [31:0] obs_b();
        return {ifb.ack, ifb.busy, ifb.bus_addr, ifb.bus_rw, ifb._devsel, ifb._iosel, ifb._iostrobe};
    endfunction

    // Expected outputs m cycles after the acceptance edge for an access to a.
    function automatic logic [31:0] exp_obs(input logic [15:0] a, input logic rw, input int m,
                                            input int s, input int t, input int h);
        logic [7:0] dev;
        logic [7:0] io;
        logic       ios;
        logic       on;
        logic       ackv;
        logic       busyv;
        int         ai;
        ai    = int'(a);
        dev   = 8'hFF;
        io    = 8'hFF;
        ios   = 1'b1;
        on    = (m > s) && (m <= s + t);
        ackv  = (m == s + t + h + 1);
        busyv = (m >= 1) && (m <= s + t + h + 1);
        if (on) begin
            if (ai >= 'hC080 && ai <= 'hC0FF)      dev = ~(8'd1 << ((ai - 'hC080) / 16));
            else if (ai >= 'hC100 && ai <= 'hC7FF) io  = ~(8'd1 << ((ai - 'hC000) / 256));
            else if (ai >= 'hC800 && ai <= 'hCFFF) ios = 1'b0;
        end
        return {ackv, busyv, a[11:0], rw, dev, io, ios};
    endfunction

    task automatic model_exp(input logic [15:0] a);
        int ai;
        ai = int'(a);
        if (ai >= 'hC100 && ai <= 'hC7FF) begin
            m_exp_slot  = 3'((ai - 'hC000) / 256);
            m_exp_valid = 1'b1;
        end else if (ai == 'hCFFF) begin
            m_exp_valid = 1'b0;
        end
    endtask

    // One full access on the default instance, starting in an idle cycle (cycle 0).
    task automatic run_access(input logic [15:0] a, input logic rw, input bit drop_early);
        int         n;
        logic [31:0] obs;
        logic [31:0] want;
        logic [3:0]  ex_old;
        logic [3:0]  ex_new;
        n      = AS + AT + AH + 1;
        ex_old = {m_exp_slot, m_exp_valid};
        model_exp(a);
        ex_new = {m_exp_slot, m_exp_valid};
        ifa.cpu_addr = a;
        ifa.cpu_rw   = rw;
        ifa.cpu_req  = 1'b1;
        _reset       = 1'b1;
        for (int m = 1; m <= n + 1; m++) begin
            next_cycle();
            if (m == 1) begin
                ifa.cpu_addr = 16'($urandom);
                ifa.cpu_rw   = ~rw;
            end
            if (drop_early && m == 2) ifa.cpu_req = 1'b0;
            if (m == n) ifa.cpu_req = 1'b0;
            obs  = obs_a();
            want = exp_obs(a, rw, m, AS, AT, AH);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL access_%h cycle %0d {ack,busy,addr,rw,devsel,iosel,iostrobe}: got %h want %h",
                         a, m, obs, want);
            end
            if (m != AS + 1) begin
                checks++;
                if ({ifa.exp_slot, ifa.exp_valid} !== ((m <= AS) ? ex_old : ex_new)) begin
                    errors++;
                    $display("FAIL exp_%h cycle %0d {exp_slot,exp_valid}: got %h want %h",
                             a, m, {ifa.exp_slot, ifa.exp_valid}, (m <= AS) ? ex_old : ex_new);
                end
            end
        end
    endtask

    task automatic test_reset;
        _reset       = 1'b0;
        ifa.cpu_req  = 1'b1;
        ifa.cpu_addr = 16'h1234;
        ifa.cpu_rw   = 1'b0;
        ifb.cpu_req  = 1'b0;
        ifb.cpu_addr = 16'h0000;
        ifb.cpu_rw   = 1'b1;
        repeat (3) next_cycle();
        checks++;
        if (obs_a() !== {1'b0, 1'b0, 12'h000, 1'b1, 8'hFF, 8'hFF, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs_a: got %h want %h", obs_a(),
                     {1'b0, 1'b0, 12'h000, 1'b1, 8'hFF, 8'hFF, 1'b1});
        end
        checks++;
        if ({ifa.exp_slot, ifa.exp_valid} !== 4'h0) begin
            errors++;
            $display("FAIL reset_exp_a: got %h want 0", {ifa.exp_slot, ifa.exp_valid});
        end
        checks++;
        if (obs_b() !== {1'b0, 1'b0, 12'h000, 1'b1, 8'hFF, 8'hFF, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs_b: got %h", obs_b());
        end
        m_exp_slot  = 3'd0;
        m_exp_valid = 1'b0;
    endtask

    // Request already high while reset releases: accepted on the first edge.
    task automatic test_first_accept;
        run_access(16'h1234, 1'b0, 1'b0);
    endtask

    task automatic test_devsel_read;
        run_access(16'hC0E5, 1'b1, 1'b0);
    endtask

    task automatic test_iosel_then_exp;
        run_access(16'hC600, 1'b0, 1'b0);
        run_access(16'hC805, 1'b1, 1'b0);
    endtask

    task automatic test_nodecode;
        run_access(16'h1234, 1'b1, 1'b0);
    endtask

    task automatic test_exp_release;
        run_access(16'hCFFF, 1'b1, 1'b0);
    endtask

    task automatic test_drop_req;
        run_access(16'hC2A0, 1'b1, 1'b1);
        run_access(16'hC0B3, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        logic [15:0] a;
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 4))
                0: a = 16'hC080 + 16'($urandom_range(0, 127));
                1: a = 16'hC100 + 16'($urandom_range(0, 'h6FF));
                2: a = 16'hC800 + 16'($urandom_range(0, 'h7FF));
                3: a = 16'hCFFF;
                default: a = 16'($urandom);
            endcase
            run_access(a, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid;
        ifa.cpu_addr = 16'hC300;
        ifa.cpu_rw   = 1'b1;
        ifa.cpu_req  = 1'b1;
        repeat (3) next_cycle();
        checks++;
        if (ifa._iosel !== 8'hF7 || ifa.exp_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: iosel %h exp_valid %b want F7 1", ifa._iosel, ifa.exp_valid);
        end
        _reset      = 1'b0;
        ifa.cpu_req = 1'b0;
        next_cycle();
        checks++;
        if ({ifa._devsel, ifa._iosel, ifa._iostrobe} !== 17'h1FFFF) begin
            errors++;
            $display("FAIL reset_mid_strobes: got %h want 1ffff", {ifa._devsel, ifa._iosel, ifa._iostrobe});
        end
        checks++;
        if ({ifa.exp_slot, ifa.exp_valid, ifa.ack, ifa.busy} !== 6'h00) begin
            errors++;
            $display("FAIL reset_mid_exp: got %h want 00", {ifa.exp_slot, ifa.exp_valid, ifa.ack, ifa.busy});
        end
        _reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            checks++;
            if (ifa.ack !== 1'b0 || ifa.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_no_ack cycle %0d: ack %b busy %b want 0 0", k, ifa.ack, ifa.busy);
            end
        end
        m_exp_slot  = 3'd0;
        m_exp_valid = 1'b0;
    endtask

    // Request held across two accesses on the SETUP=2/STROBE=1/HOLD=3 instance.
    task automatic test_back_to_back;
        logic [15:0] a0;
        logic [15:0] a1;
        logic        r0;
        logic        r1;
        logic [31:0] want;
        int          p;
        int          m;
        p  = BS + BT + BH + 2;
        a0 = 16'hC0A2;
        r0 = 1'b1;
        a1 = 16'hC400 | 16'($urandom_range(0, 255));
        r1 = 1'b0;
        ifb.cpu_addr = a0;
        ifb.cpu_rw   = r0;
        ifb.cpu_req  = 1'b1;
        for (int k = 1; k <= 2 * p; k++) begin
            next_cycle();
            if (k == 1) begin
                ifb.cpu_addr = a1;
                ifb.cpu_rw   = r1;
            end
            if (k == 2 * p - 1) ifb.cpu_req = 1'b0;
            m    = (k <= p) ? k : k - p;
            want = (k <= p) ? exp_obs(a0, r0, m, BS, BT, BH) : exp_obs(a1, r1, m, BS, BT, BH);
            checks++;
            if (obs_b() !== want) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %h want %h", k, obs_b(), want);
            end
        end
        checks++;
        if ({ifb.exp_slot, ifb.exp_valid} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL back_to_back_exp: got %h want 9", {ifb.exp_slot, ifb.exp_valid});
        end
    endtask

    initial begin
        test_reset();
        test_first_accept();
        test_devsel_read();
        test_iosel_then_exp();
        test_nodecode();
        test_exp_release();
        test_drop_req();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
